// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end with single outstanding request and in-order buffer
// Optional misaligned-redirect trap: define IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [6:0]      op_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            misalign_o
);

  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CNT_W = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic               misalign_q, misalign_d;
  logic [XLEN-1:0]    buf_instr_q [BUF_DEPTH];
  logic [XLEN-1:0]    buf_pc_q    [BUF_DEPTH];

  logic               pop;
  logic               push;
  logic               req_fire;
  logic [XLEN-1:0]    redir_pc;
  logic               redir_bad;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redir_pc  = redirect_pc_i;
  assign redir_bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
  // Low target bits are ignored entirely: every redirect lands word aligned.
  logic unused_redir_low;
  assign unused_redir_low = ^redirect_pc_i[1:0];
  assign redir_pc  = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  assign pop      = (cnt_q != '0) & instr_ready_i;
  assign req_fire = req_valid_q & imem_req_ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    misalign_d = misalign_q;
    push       = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A redirect overrides the sequential path; an accepted-but-unanswered
    // request must still have its stale response swallowed in DROP.
    if (redirect_i) begin
      fetch_pc_d = redir_pc;
      misalign_d = redir_bad;
      push       = 1'b0;
      case (state_q)
        S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end

    if (redirect_i) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    req_valid_d = (state_d == S_REQ) && (cnt_d < CNT_W'(BUF_DEPTH)) && !misalign_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      misalign_q  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      misalign_q  <= misalign_d;
      if (push) begin
        buf_instr_q[wr_ptr_q] <= imem_rsp_data_i;
        buf_pc_q[wr_ptr_q]    <= req_pc_q;
      end
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = fetch_pc_q;
  assign instr_valid_o    = (cnt_q != '0);
  assign instr_o          = buf_instr_q[rd_ptr_q];
  assign instr_pc_o       = buf_pc_q[rd_ptr_q];
  assign op_o             = buf_instr_q[rd_ptr_q][6:0];
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a variable-latency memory model
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  logic [31:0] rsp_addr;
  logic [31:0] paddr;
  logic        busy;
  int          mcnt;
  int          lat;

  logic [31:0] req_log [$];
  logic [31:0] exp_q [$];
  int          pops;
  int          total;
  int          bad;
  logic [31:0] mon_e;
  logic [31:0] mon_i;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (mem_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (dec_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .op_o             (op),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .misalign_o       (misalign)
  );

  // Memory: returns addr|0x13, response consumed lat cycles after acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      paddr     <= '0;
      busy      <= 1'b0;
      mcnt      <= 0;
    end else begin
      rsp_valid <= 1'b0;
      if (busy) begin
        if (mcnt <= 1) begin
          rsp_valid <= 1'b1;
          rsp_data  <= paddr | 32'h13;
          rsp_addr  <= paddr;
          busy      <= 1'b0;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
      if (req_valid && mem_ready) begin
        if (lat <= 1) begin
          rsp_valid <= 1'b1;
          rsp_data  <= req_addr | 32'h13;
          rsp_addr  <= req_addr;
        end else begin
          busy  <= 1'b1;
          paddr <= req_addr;
          mcnt  <= lat - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && req_valid && mem_ready) req_log.push_back(req_addr);
    if (!rst && instr_valid && dec_ready) begin
      pops++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_i = mon_e | 32'h13;
        total++;
        if (instr_pc !== mon_e || instr !== mon_i || op !== mon_i[6:0]) begin
          bad++;
          $display("FAIL pop_stream pc=%h instr=%h op=%h required pc=%h instr=%h op=%h",
                   instr_pc, instr, op, mon_e, mon_i, mon_i[6:0]);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pops >= target) break;
      step;
    end
  endtask

  task automatic sync_to(input logic [31:0] pc);
    mem_ready = 1'b0;
    dec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy && !rsp_valid) break;
      step;
    end
    step;
    redirect    = 1'b1;
    redirect_pc = pc;
    step;
    redirect    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ready = 1'b1; lat = 1; dec_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    repeat (3) step;
    total++;
    if (req_valid !== 1'b0 || req_addr !== 32'h0 || misalign !== 1'b0) begin
      bad++; $display("FAIL reset_req valid=%b addr=%h mis=%b required 0 00000000 0", req_valid, req_addr, misalign);
    end
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || op !== 7'h0) begin
      bad++; $display("FAIL reset_instr v=%b i=%h pc=%h op=%h required all zero", instr_valid, instr, instr_pc, op);
    end
    rst = 1'b0;
    step;
    total++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      bad++; $display("FAIL first_req valid=%b addr=%h required 1 00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_first_fetch;
    step;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL early_valid got=%b required 0", instr_valid);
    end
    step;
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h0 || op !== 7'h13) begin
      bad++; $display("FAIL first_instr v=%b i=%h pc=%h op=%h required 1 00000013 00000000 13", instr_valid, instr, instr_pc, op);
    end
  endtask

  task automatic test_backpressure;
    int p0;
    repeat (10) step;
    total++;
    if (req_log.size() != 2 || req_valid !== 1'b0 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL full_hold reqs=%0d valid=%b head=%h required 2 0 00000000", req_log.size(), req_valid, instr_pc);
    end
    total++;
    if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
      bad++; $display("FAIL first_addrs count=%0d required 0,4", req_log.size());
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    p0 = pops;
    dec_ready = 1'b1;
    wait_pops(p0 + 4, 60);
    dec_ready = 1'b0;
    total++;
    if (pops != p0 + 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL drain pops=%0d left=%0d required %0d 0", pops - p0, exp_q.size(), 4);
    end
    total++;
    if (req_log.size() < 3 || req_log[2] !== 32'h8) begin
      bad++; $display("FAIL resume_addr count=%0d required third request 00000008", req_log.size());
    end
  endtask

  task automatic test_redirect_wait;
    int n, p0;
    bit got;
    lat = 3;
    sync_to(32'h8);
    n = req_log.size();
    mem_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (req_log.size() > n) begin got = 1; break; end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL wait_accept timeout got=0 required 1");
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    step;
    redirect = 1'b0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    p0 = pops;
    dec_ready = 1'b1;
    wait_pops(p0 + 2, 60);
    dec_ready = 1'b0;
    total++;
    if (pops != p0 + 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL redirect_stream pops=%0d left=%0d required 2 0", pops - p0, exp_q.size());
    end
    total++;
    if (req_log.size() < n + 2 || req_log[n] !== 32'h8 || req_log[n+1] !== 32'h100) begin
      bad++; $display("FAIL redirect_addr count=%0d required 00000008 then 00000100", req_log.size() - n);
    end
  endtask

  task automatic test_same_cycle;
    int p0;
    bit found;
    lat = 3;
    sync_to(32'h40);
    mem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step;
      if (rsp_valid && rsp_addr == 32'h44) begin found = 1; break; end
    end
    total++;
    if (!found || instr_valid !== 1'b1) begin
      bad++; $display("FAIL same_setup found=%0d head_valid=%b required 1 1", found, instr_valid);
    end
    exp_q.push_back(32'h40);
    p0 = pops;
    redirect = 1'b1; redirect_pc = 32'h300; dec_ready = 1'b1;
    step;
    redirect = 1'b0; dec_ready = 1'b0;
    total++;
    if (pops != p0 + 1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL same_flush pops=%0d valid=%b required 1 0", pops - p0, instr_valid);
    end
    total++;
    if (req_valid !== 1'b1 || req_addr !== 32'h300) begin
      bad++; $display("FAIL same_req valid=%b addr=%h required 1 00000300", req_valid, req_addr);
    end
    exp_q.push_back(32'h300);
    dec_ready = 1'b1;
    wait_pops(p0 + 2, 40);
    dec_ready = 1'b0;
    total++;
    if (pops != p0 + 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL same_next pops=%0d left=%0d required 2 0", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_wrap;
    int n, p0;
    lat = 1;
    sync_to(32'hFFFF_FFFC);
    n = req_log.size();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    p0 = pops;
    mem_ready = 1'b1;
    dec_ready = 1'b1;
    wait_pops(p0 + 3, 60);
    dec_ready = 1'b0;
    total++;
    if (pops != p0 + 3 || exp_q.size() != 0) begin
      bad++; $display("FAIL wrap_stream pops=%0d left=%0d required 3 0", pops - p0, exp_q.size());
    end
    total++;
    if (req_log.size() < n + 2 || req_log[n] !== 32'hFFFF_FFFC || req_log[n+1] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr count=%0d required fffffffc then 00000000", req_log.size() - n);
    end
  endtask

  task automatic test_async_reset;
    lat = 3; mem_ready = 1'b1; dec_ready = 1'b0;
    repeat (3) step;
    #2 rst = 1'b1;
    #1;
    total++;
    if (req_valid !== 1'b0 || instr_valid !== 1'b0 || req_addr !== 32'h0) begin
      bad++; $display("FAIL async_reset valid=%b ivalid=%b addr=%h required 0 0 00000000", req_valid, instr_valid, req_addr);
    end
    step;
    rst = 1'b0;
    step;
    total++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      bad++; $display("FAIL post_reset_req valid=%b addr=%h required 1 00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_misalign;
    int n;
    lat = 1;
    sync_to(32'h180);
    n = req_log.size();
    redirect = 1'b1; redirect_pc = 32'h102;
    step;
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    total++;
    if (misalign !== 1'b1 || req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL mis_set mis=%b valid=%b ivalid=%b required 1 0 0", misalign, req_valid, instr_valid);
    end
    mem_ready = 1'b1;
    repeat (5) step;
    total++;
    if (req_log.size() != n || req_valid !== 1'b0) begin
      bad++; $display("FAIL mis_halt new_reqs=%0d valid=%b required 0 0", req_log.size() - n, req_valid);
    end
    mem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200;
    step;
    redirect = 1'b0;
    total++;
    if (misalign !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200) begin
      bad++; $display("FAIL mis_clear mis=%b valid=%b addr=%h required 0 1 00000200", misalign, req_valid, req_addr);
    end
`else
    total++;
    if (misalign !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100) begin
      bad++; $display("FAIL mis_forced mis=%b valid=%b addr=%h required 0 1 00000100", misalign, req_valid, req_addr);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; pops = 0;
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_redirect_wait;
    test_same_cycle;
    test_wrap;
    test_async_reset;
    test_misalign;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
